// File: rtl/rv_alu_v.sv
// RV32I execute-stage ALU: decodes opcode/funct3/funct7 and registers one
// 32-bit result per cycle (ALU value, effective address, jump target or branch flag).
module rv_alu_v (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    output logic [31:0] Rez
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    logic               alt;
    logic               lt_s;
    logic               lt_u;
    logic               eq;
    logic               taken;
    logic               unused_funct7;
    logic [31:0]        sum;
    logic [31:0]        diff;
    logic [31:0]        srl_res;
    logic signed [31:0] sra_res;
    logic [31:0]        alu_res;
    logic [31:0]        r;

    assign alt     = funct7[5];
    assign sum     = Op1 + Op2;
    assign diff    = Op1 - Op2;
    assign lt_s    = $signed(Op1) < $signed(Op2);
    assign lt_u    = Op1 < Op2;
    assign eq      = (Op1 == Op2);
    assign srl_res = Op1 >> Op2[4:0];
    // Kept in its own signed net so the arithmetic shift is not demoted to logical.
    assign sra_res = $signed(Op1) >>> Op2[4:0];

    // Only funct7[5] selects anything; the remaining bits are don't-care.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Shared OP / OP-IMM datapath; funct7[5] selects SUB only for register-register ops.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && alt) ? diff : sum;
            3'b001: alu_res = Op1 << Op2[4:0];
            3'b010: alu_res = {31'd0, lt_s};
            3'b011: alu_res = {31'd0, lt_u};
            3'b100: alu_res = Op1 ^ Op2;
            3'b101: alu_res = alt ? sra_res : srl_res;
            3'b110: alu_res = Op1 | Op2;
            3'b111: alu_res = Op1 & Op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        r = '0;
        case (opcode)
            OPC_LUI:                        r = Op2;
            OPC_AUIPC, OPC_LOAD, OPC_STORE,
            OPC_JAL:                        r = sum;
            OPC_OP_IMM, OPC_OP:             r = alu_res;
            OPC_BRANCH:                     r = {31'd0, taken};
            OPC_JALR:                       r = sum & 32'hFFFF_FFFE;
            default:                        r = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            Rez <= '0;
        end else begin
            Rez <= r;
        end
    end

endmodule

// File: tb/tb_rv_alu_v.sv
// Self-checking bench for rv_alu_v: expected results are queued when stimulus
// is driven and compared one cycle later when the registered result appears.
module tb_rv_alu_v;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic [31:0] Rez;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  monitor_en = 1'b0;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    rv_alu_v dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .Op1    (Op1),
        .Op2    (Op2),
        .Rez    (Rez)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one operation at the falling edge and queue its expected result.
    task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        sb_t e;
        @(negedge clk);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        Op1    = a;
        Op2    = b;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic apply_word(input string tag, input logic [31:0] word, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        apply(tag, word[6:0], word[14:12], word[31:25], a, b, exp);
    endtask

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (monitor_en && sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, Rez, e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        opcode = 7'd0;
        funct3 = 3'd0;
        funct7 = 7'd0;
        Op1    = 32'd0;
        Op2    = 32'd0;

        // Async reset before any clock edge.
        #1 rst = 1'b1;
        #2 check("reset_state", Rez, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        monitor_en = 1'b1;

        // Instruction-word scenarios, Op1=3 / Op2=2.
        apply_word("lui_50b7",  32'h000050B7, 32'd3, 32'd2, 32'd2);
        apply_word("lui_0137",  32'h00000137, 32'd3, 32'd2, 32'd2);
        apply_word("addi",      32'h00508193, 32'd3, 32'd2, 32'd5);
        apply_word("load",      32'h00502083, 32'd3, 32'd2, 32'd5);
        apply_word("beq_ne",    32'hFE000CE3, 32'd3, 32'd2, 32'd0);
        apply_word("lui_7237",  32'h00077237, 32'd3, 32'd2, 32'd2);
        apply_word("srli",      32'h00C0D093, 32'd3, 32'd2, 32'd0);
        apply_word("jal",       32'hFF9FF2EF, 32'd3, 32'd2, 32'd5);

        // OP with Op1=0x8000_0000, Op2=4.
        apply("srl",  OP, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'h0800_0000);
        apply("sra",  OP, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000);
        apply("sub",  OP, 3'b000, 7'h20, 32'h8000_0000, 32'd4, 32'h7FFF_FFFC);
        apply("slt",  OP, 3'b010, 7'h00, 32'h8000_0000, 32'd4, 32'd1);
        apply("sltu", OP, 3'b011, 7'h00, 32'h8000_0000, 32'd4, 32'd0);

        // Branches with Op1=-1, Op2=1.
        apply("blt",    BRANCH, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("bge",    BRANCH, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("bltu",   BRANCH, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("bgeu",   BRANCH, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("bne",    BRANCH, 3'b001, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("br_010", BRANCH, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("beq_eq", BRANCH, 3'b000, 7'h00, 32'd7, 32'd7, 32'd1);
        apply("bge_eq", BRANCH, 3'b101, 7'h00, 32'd7, 32'd7, 32'd1);
        apply("bltu_eq", BRANCH, 3'b110, 7'h00, 32'd7, 32'd7, 32'd0);

        // Wrap and mask edge cases.
        apply("add_wrap",  OP,          3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("sll_mask",  OP,          3'b001, 7'h00, 32'd1, 32'h25, 32'h20);
        apply("sll_31",    OP,          3'b001, 7'h00, 32'd1, 32'd31, 32'h8000_0000);
        apply("jalr_mask", 7'b1100111,  3'b000, 7'h00, 32'h1001, 32'd0, 32'h1000);
        apply("unknown",   7'h7F,       3'b000, 7'h00, 32'd3, 32'd2, 32'd0);

        // Remaining opcodes and logic ops.
        apply("auipc", 7'b0010111, 3'b000, 7'h00, 32'h1000, 32'h5000, 32'h6000);
        apply("store", 7'b0100011, 3'b010, 7'h00, 32'h100, 32'hFFFF_FFFC, 32'hFC);
        apply("xori",  OP_IMM, 3'b100, 7'h00, 32'hF0F0, 32'h0FF0, 32'hFF00);
        apply("ori",   OP_IMM, 3'b110, 7'h00, 32'hF0F0, 32'h0FF0, 32'hFFF0);
        apply("andi",  OP_IMM, 3'b111, 7'h00, 32'hF0F0, 32'h0FF0, 32'h00F0);
        apply("addi_f7", OP_IMM, 3'b000, 7'h20, 32'd3, 32'd2, 32'd5);
        apply("srai",  OP_IMM, 3'b101, 7'h20, 32'h8000_0000, 32'h404, 32'hF800_0000);
        apply("slti",  OP_IMM, 3'b010, 7'h00, 32'hFFFF_FFFE, 32'd1, 32'd1);
        apply("sltiu", OP_IMM, 3'b011, 7'h00, 32'hFFFF_FFFE, 32'd1, 32'd0);
        apply("xor_op", OP, 3'b100, 7'h00, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) check("sb_drain", 32'(sb.size()), 32'd0);
        monitor_en = 1'b0;

        // Reset mid-stream: load 5, then assert rst between edges.
        @(negedge clk);
        opcode = OP_IMM; funct3 = 3'b000; funct7 = 7'h00; Op1 = 32'd3; Op2 = 32'd2;
        @(posedge clk);
        #1 check("pre_reset", Rez, 32'd5);
        #3 rst = 1'b1;
        #1 check("rst_async", Rez, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("rst_hold", Rez, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        Op1 = 32'd10; Op2 = 32'd20;
        #1 check("rst_release", Rez, 32'd0);
        @(posedge clk);
        #1 check("post_reset", Rez, 32'd30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
